arb_mux_4_1_n_bit: RTL and testbench

ARB_MUX_4_1_N_BIT -- requirements
Module: arb_mux_4_1_n_bit

---
 rtl/arb_mux_4_1_n_bit.sv | 106 ++++++++++
 tb/tb_arb_mux_4_1_n_bit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_4_1_n_bit.sv
// Four-channel round-robin arbiter feeding a one-entry registered output stage.
// Each channel uses valid/ready handshakes. out_sel holds the granted channel
// index in binary, so it can drive a 1:4 demux select directly.
module arb_mux_4_1_n_bit #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i0,
  input  logic [N-1:0] i1,
  input  logic [N-1:0] i2,
  input  logic [N-1:0] i3,
  input  logic [3:0]   in_valid,
  output logic [3:0]   in_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   out_sel,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [N-1:0] out_data_q, out_data_d;
  logic [1:0]   out_sel_q, out_sel_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   ptr_q, ptr_d;

  logic [1:0]   grant;
  logic         grant_vld;
  logic [1:0]   idx;
  logic         load;
  logic         take;
  logic [N-1:0] sel_data;

  // Rotating priority scan: walk from ptr+3 down to ptr, so the channel
  // closest to ptr is the one left standing.
  always_comb begin
    grant_vld = 1'b0;
    grant     = 2'd0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Handshake decode. The output register can accept a word when it is empty
  // or is being drained this cycle; reset forces every ready low.
  always_comb begin
    load     = !out_valid_q || out_ready;
    take     = rst_n && load && grant_vld;
    in_ready = take ? (4'b0001 << grant) : 4'b0000;
  end

  // Data path mux for the granted channel.
  always_comb begin
    sel_data = i0;
    case (grant)
      2'd0: sel_data = i0;
      2'd1: sel_data = i1;
      2'd2: sel_data = i2;
      2'd3: sel_data = i3;
      default: sel_data = i0;
    endcase
  end

  // Next state. A drain and a load in the same cycle collapse into one load.
  // An empty load cycle clears valid but keeps data, sel and ptr.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant_vld) begin
        out_data_d  = sel_data;
        out_sel_d   = grant;
        out_valid_d = 1'b1;
        ptr_d       = grant + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_4_1_n_bit.sv
// Testbench for arb_mux_4_1_n_bit. A 4-bit instance runs directed scenarios.
// An 8-bit instance runs random traffic against a queue-based scoreboard.
module tb_arb_mux_4_1_n_bit;

  logic clk;
  logic rst_n;

  // 4-bit instance signals
  logic [3:0] a0, a1, a2, a3;
  logic [3:0] a_in_valid, a_in_ready;
  logic [3:0] a_out_data;
  logic [1:0] a_out_sel;
  logic       a_out_valid, a_out_ready;

  // 8-bit instance signals
  logic [7:0] b0, b1, b2, b3;
  logic [3:0] b_in_valid, b_in_ready;
  logic [7:0] b_out_data;
  logic [1:0] b_out_sel;
  logic       b_out_valid, b_out_ready;

  int vectors;
  int miscompares;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  arb_mux_4_1_n_bit #(.N(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0       (a0),
    .i1       (a1),
    .i2       (a2),
    .i3       (a3),
    .in_valid (a_in_valid),
    .in_ready (a_in_ready),
    .out_data (a_out_data),
    .out_sel  (a_out_sel),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  arb_mux_4_1_n_bit #(.N(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i0       (b0),
    .i1       (b1),
    .i2       (b2),
    .i3       (b3),
    .in_valid (b_in_valid),
    .in_ready (b_in_ready),
    .out_data (b_out_data),
    .out_sel  (b_out_sel),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [1:0] s,
                       input logic [3:0] d);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, ".sel"}, 32'(a_out_sel), 32'(s));
    chk({tag, ".data"}, 32'(a_out_data), 32'(d));
  endtask

  // Scoreboard model state for the 8-bit instance.
  logic [1:0] m_ptr;
  logic       m_valid;

  initial begin
    logic [3:0] exp_ir;
    logic       m_load;
    logic       found;
    logic [1:0] g;
    logic [7:0] gd;
    exp_t       e;

    vectors     = 0;
    miscompares = 0;
    m_ptr       = 2'd0;
    m_valid     = 1'b0;

    rst_n       = 1'b0;
    a0 = 4'h1; a1 = 4'h2; a2 = 4'h3; a3 = 4'h4;
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b1;
    b0 = 8'h0; b1 = 8'h0; b2 = 8'h0; b3 = 8'h0;
    b_in_valid  = 4'b0000;
    b_out_ready = 1'b0;

    // Reset held for two edges with every channel requesting
    edge1();
    chk("rst1.in_ready", 32'(a_in_ready), 32'h0);
    chk_a("rst1", 1'b0, 2'd0, 4'h0);
    edge1();
    chk("rst2.in_ready", 32'(a_in_ready), 32'h0);
    chk_a("rst2", 1'b0, 2'd0, 4'h0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", 32'(a_in_ready), 32'h1);

    // Round robin across all four channels, then wrap back to channel 0
    for (int k = 0; k < 5; k++) begin
      edge1();
      chk_a($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 4'(k % 4 + 1));
    end

    // Channel 2 alone, then channels 3 and 1 with ptr at 3
    a_in_valid = 4'b0100;
    a2 = 4'h9;
    #1;
    chk("ptr.ir2", 32'(a_in_ready), 32'h4);
    edge1();
    chk_a("ptr.ch2", 1'b1, 2'b10, 4'h9);
    a_in_valid = 4'b1010;
    #1;
    chk("ptr.ir3", 32'(a_in_ready), 32'h8);
    edge1();
    chk_a("ptr.ch3", 1'b1, 2'd3, 4'h4);
    #1;
    chk("ptr.ir1", 32'(a_in_ready), 32'h2);
    edge1();
    chk_a("ptr.ch1", 1'b1, 2'd1, 4'h2);

    // Three stall cycles with every channel requesting; ptr is 2
    a2 = 4'h3;
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b0;
    #1;
    chk("bp.ir0", 32'(a_in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk_a($sformatf("bp%0d", k), 1'b1, 2'd1, 4'h2);
      chk($sformatf("bp%0d.ir", k), 32'(a_in_ready), 32'h0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp.release.ir", 32'(a_in_ready), 32'h4);
    edge1();
    chk_a("bp.after", 1'b1, 2'd2, 4'h3);

    // Get ptr to 2 with a held word, then reset while stalled
    a_in_valid = 4'b0010;
    #1;
    chk("mid.ir1", 32'(a_in_ready), 32'h2);
    edge1();
    chk_a("mid.ch1", 1'b1, 2'd1, 4'h2);
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("mid.rst.ir", 32'(a_in_ready), 32'h0);
    edge1();
    chk_a("mid.rst", 1'b0, 2'd0, 4'h0);
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    #1;
    chk("mid.rel.ir", 32'(a_in_ready), 32'h1);
    edge1();
    chk_a("mid.first", 1'b1, 2'd0, 4'h1);

    // Nothing offered: valid drops, data and sel hold
    a_in_valid = 4'b0000;
    #1;
    chk("idle.ir", 32'(a_in_ready), 32'h0);
    edge1();
    chk_a("idle", 1'b0, 2'd0, 4'h1);

    // Random traffic on the 8-bit instance (first half: all channels valid)
    for (int cyc = 0; cyc < 300; cyc++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      b_in_valid  = (cyc < 150) ? 4'b1111 : 4'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("sb.valid", 32'(b_out_valid), 32'(m_valid));
      if (m_valid && b_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb.underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb.data", 32'(b_out_data), 32'(e.data));
          chk("sb.sel", 32'(b_out_sel), 32'(e.sel));
        end
      end
      m_load = !m_valid || b_out_ready;
      found  = 1'b0;
      g      = 2'd0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (int'(m_ptr) + k) % 4;
        if (!found && b_in_valid[c]) begin
          found = 1'b1;
          g     = 2'(c);
        end
      end
      exp_ir = (m_load && found) ? 4'(1 << g) : 4'b0000;
      chk("sb.in_ready", 32'(b_in_ready), 32'(exp_ir));
      if (m_load) begin
        if (found) begin
          case (g)
            2'd0: gd = b0;
            2'd1: gd = b1;
            2'd2: gd = b2;
            default: gd = b3;
          endcase
          e.sel  = g;
          e.data = gd;
          exp_q.push_back(e);
          m_ptr   = g + 2'd1;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      edge1();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
